// File: rtl/alu_unit.sv
// Integer ALU execution unit with a small result FIFO
// feeding the common data bus through a request/grant pair.
module alu_unit #(
  parameter int WIDTH     = 32,
  parameter int C_WIDTH   = 4,
  parameter int TAG_WIDTH = 4,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issueValid,
  output logic                 issueReady,
  input  logic [WIDTH-1:0]     src1,
  input  logic [WIDTH-1:0]     src2,
  input  logic [C_WIDTH-1:0]   aluControl,
  input  logic [TAG_WIDTH-1:0] issueTag,
  input  logic                 flush,
  input  logic                 cdbGrant,
  output logic                 aluRequest,
  output logic [WIDTH-1:0]     result,
  output logic [TAG_WIDTH-1:0] resultTag
);

  localparam int SW = $clog2(WIDTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [C_WIDTH-1:0] OP_ADD = C_WIDTH'(0);
  localparam logic [C_WIDTH-1:0] OP_AND = C_WIDTH'(1);
  localparam logic [C_WIDTH-1:0] OP_OR  = C_WIDTH'(2);
  localparam logic [C_WIDTH-1:0] OP_XOR = C_WIDTH'(3);
  localparam logic [C_WIDTH-1:0] OP_SLT = C_WIDTH'(4);
  localparam logic [C_WIDTH-1:0] OP_SLTU = C_WIDTH'(5);
  localparam logic [C_WIDTH-1:0] OP_SLL = C_WIDTH'(6);
  localparam logic [C_WIDTH-1:0] OP_SRL = C_WIDTH'(7);
  localparam logic [C_WIDTH-1:0] OP_SUB = C_WIDTH'(8);
  localparam logic [C_WIDTH-1:0] OP_SRA = C_WIDTH'(9);

  logic [WIDTH-1:0]     res_q [DEPTH];
  logic [WIDTH-1:0]     res_d [DEPTH];
  logic [TAG_WIDTH-1:0] tag_q [DEPTH];
  logic [TAG_WIDTH-1:0] tag_d [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;

  logic [WIDTH-1:0] alu_res;
  logic             legal;
  logic [SW-1:0]    shamt;
  logic             accept;
  logic             push;
  logic             pop;

  assign shamt = src2[SW-1:0];

  assign aluRequest = (cnt_q != '0);
  assign result     = aluRequest ? res_q[head_q] : '0;
  assign resultTag  = aluRequest ? tag_q[head_q] : '0;

  assign issueReady = rdy_q &
                      ((cnt_q < FULL) | (aluRequest & cdbGrant));

  assign accept = issueValid & issueReady & ~flush;
  assign push   = accept & legal;
  assign pop    = aluRequest & cdbGrant & ~flush;

  // Operation decode and datapath; unknown codes flag illegal.
  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    unique case (1'b1)
      (aluControl == OP_ADD): alu_res = src1 + src2;
      (aluControl == OP_AND): alu_res = src1 & src2;
      (aluControl == OP_OR):  alu_res = src1 | src2;
      (aluControl == OP_XOR): alu_res = src1 ^ src2;
      (aluControl == OP_SLT):
        alu_res = {{(WIDTH-1){1'b0}},
                   ($signed(src1) < $signed(src2))};
      (aluControl == OP_SLTU):
        alu_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
      (aluControl == OP_SLL): alu_res = src1 << shamt;
      (aluControl == OP_SRL): alu_res = src1 >> shamt;
      (aluControl == OP_SUB): alu_res = src1 - src2;
      (aluControl == OP_SRA):
        alu_res = $signed(src1) >>> shamt;
      default: legal = 1'b0;
    endcase
  end

  // FIFO next state: push at tail, pop at head, flush clears.
  always_comb begin
    res_d  = res_q;
    tag_d  = tag_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    rdy_d  = 1'b1;
    if (push) begin
      res_d[tail_q] = alu_res;
      tag_d[tail_q] = issueTag;
      tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    end
    if (pop) begin
      head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  // State registers; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      tag_q  <= tag_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: opcode table plus
// FIFO, flush, illegal-op and reset sequences.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic        issueValid;
  logic        issueReady;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  aluControl;
  logic [3:0]  issueTag;
  logic        flush;
  logic        cdbGrant;
  logic        aluRequest;
  logic [31:0] result;
  logic [3:0]  resultTag;

  int n_total;
  int n_pass;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  alu_unit #(
    .WIDTH(32), .C_WIDTH(4), .TAG_WIDTH(4), .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .issueValid(issueValid),
    .issueReady(issueReady),
    .src1(src1),
    .src2(src2),
    .aluControl(aluControl),
    .issueTag(issueTag),
    .flush(flush),
    .cdbGrant(cdbGrant),
    .aluRequest(aluRequest),
    .result(result),
    .resultTag(resultTag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_add(input logic [3:0] tag);
    issueValid = 1'b1;
    aluControl = 4'd0;
    src1 = 32'(tag) * 10;
    src2 = 32'd0;
    issueTag = tag;
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    rst_n = 1'b0;
    issueValid = 1'b0;
    src1 = '0;
    src2 = '0;
    aluControl = '0;
    issueTag = '0;
    flush = 1'b0;
    cdbGrant = 1'b0;

    vecs[0]  = '{4'd0, 32'd7, 32'hFFFF_FFFD, 4'd5, 32'd4};
    vecs[1]  = '{4'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd1, 32'h00F0_1234};
    vecs[2]  = '{4'd2, 32'hF000_0000, 32'h0000_000F, 4'd2, 32'hF000_000F};
    vecs[3]  = '{4'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd3, 32'hF0F0_0F0F};
    vecs[4]  = '{4'd4, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd1};
    vecs[5]  = '{4'd5, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd0};
    vecs[6]  = '{4'd6, 32'd1, 32'h21, 4'd7, 32'd2};
    vecs[7]  = '{4'd7, 32'h8000_0000, 32'd4, 4'd8, 32'h0800_0000};
    vecs[8]  = '{4'd8, 32'd5, 32'd7, 4'd9, 32'hFFFF_FFFE};
    vecs[9]  = '{4'd9, 32'h8000_0000, 32'h24, 4'd10, 32'hF800_0000};
    vecs[10] = '{4'd0, 32'hFFFF_FFFF, 32'd1, 4'd11, 32'd0};
    vecs[11] = '{4'd4, 32'd1, 32'hFFFF_FFFF, 4'd12, 32'd0};

    // reset state
    #1;
    check("rst_ready", 32'(issueReady), 32'd0);
    check("rst_req", 32'(aluRequest), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_tag", 32'(resultTag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(issueReady), 32'd0);
    step();
    check("ready_after_edge", 32'(issueReady), 32'd1);

    // opcode table
    for (int i = 0; i < 12; i++) begin
      issueValid = 1'b1;
      aluControl = vecs[i].ctrl;
      src1 = vecs[i].a;
      src2 = vecs[i].b;
      issueTag = vecs[i].tag;
      step();
      issueValid = 1'b0;
      check($sformatf("v%0d_req", i), 32'(aluRequest), 32'd1);
      check($sformatf("v%0d_result", i), result, vecs[i].exp);
      check($sformatf("v%0d_tag", i), 32'(resultTag), 32'(vecs[i].tag));
      cdbGrant = 1'b1;
      step();
      cdbGrant = 1'b0;
      check($sformatf("v%0d_drain", i), 32'(aluRequest), 32'd0);
    end

    // FIFO fill, full stall, pop+push when full, drain order
    issue_add(4'd1);
    step();
    check("f1_tag", 32'(resultTag), 32'd1);
    check("f1_ready", 32'(issueReady), 32'd1);
    issue_add(4'd2);
    step();
    check("f2_ready", 32'(issueReady), 32'd0);
    check("f2_tag", 32'(resultTag), 32'd1);
    issue_add(4'd3);
    step();
    check("f3_stall_ready", 32'(issueReady), 32'd0);
    check("f3_head", result, 32'd10);
    cdbGrant = 1'b1;
    #1;
    check("f_ready_grant", 32'(issueReady), 32'd1);
    step();
    cdbGrant = 1'b0;
    issue_add(4'd4);
    #1;
    check("f_full_again", 32'(issueReady), 32'd0);
    check("f_head2_tag", 32'(resultTag), 32'd2);
    issueValid = 1'b0;
    cdbGrant = 1'b1;
    step();
    check("f_head3_tag", 32'(resultTag), 32'd3);
    check("f_head3_res", result, 32'd30);
    step();
    cdbGrant = 1'b0;
    check("f_empty", 32'(aluRequest), 32'd0);

    // flush with grant and issue pending
    issue_add(4'd7);
    step();
    issue_add(4'd8);
    step();
    check("fl_full", 32'(issueReady), 32'd0);
    issue_add(4'd9);
    flush = 1'b1;
    cdbGrant = 1'b1;
    step();
    flush = 1'b0;
    cdbGrant = 1'b0;
    issueValid = 1'b0;
    check("fl_req", 32'(aluRequest), 32'd0);
    check("fl_result", result, 32'd0);
    check("fl_tag", 32'(resultTag), 32'd0);
    check("fl_ready", 32'(issueReady), 32'd1);
    step();
    check("fl_req_later", 32'(aluRequest), 32'd0);

    // illegal encoding is dropped
    issueValid = 1'b1;
    aluControl = 4'd12;
    src1 = 32'd3;
    src2 = 32'd4;
    issueTag = 4'd6;
    step();
    issueValid = 1'b0;
    check("ill_req", 32'(aluRequest), 32'd0);
    check("ill_ready", 32'(issueReady), 32'd1);
    step();
    check("ill_req2", 32'(aluRequest), 32'd0);

    // asynchronous reset mid-cycle with an entry buffered
    issue_add(4'd13);
    step();
    issueValid = 1'b0;
    check("ar_req_pre", 32'(aluRequest), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req", 32'(aluRequest), 32'd0);
    check("ar_result", result, 32'd0);
    check("ar_ready", 32'(issueReady), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ar_ready_rel", 32'(issueReady), 32'd0);
    step();
    check("ar_ready_edge", 32'(issueReady), 32'd1);
    check("ar_no_req", 32'(aluRequest), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
